// File: rtl/plot_arbiter.sv
// Multi-client rectangle-fill front end for the 160x120 VGA adapter.
// Round-robin grants one rectangle at a time and plots it one pixel per clock.
module plot_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 6,
  parameter int SIZE_W   = 3,
  parameter int H_RES    = 160,
  parameter int V_RES    = 120
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*X_W-1:0]        req_x,
  input  logic [NUM_CH*Y_W-1:0]        req_y,
  input  logic [NUM_CH*COLOUR_W-1:0]   req_colour,
  input  logic [NUM_CH*SIZE_W-1:0]     req_w,
  input  logic [NUM_CH*SIZE_W-1:0]     req_h,
  output logic [X_W-1:0]               X,
  output logic [Y_W-1:0]               Y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         writeEn,
  output logic                         busy,
  output logic [2:0]                   grant_id
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DRAW = 1'b1;

  logic [NUM_CH-1:0][X_W-1:0]      w_x;
  logic [NUM_CH-1:0][Y_W-1:0]      w_y;
  logic [NUM_CH-1:0][COLOUR_W-1:0] w_col;
  logic [NUM_CH-1:0][SIZE_W-1:0]   w_w;
  logic [NUM_CH-1:0][SIZE_W-1:0]   w_h;

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_x[g]   = req_x[g*X_W +: X_W];
    assign w_y[g]   = req_y[g*Y_W +: Y_W];
    assign w_col[g] = req_colour[g*COLOUR_W +: COLOUR_W];
    assign w_w[g]   = req_w[g*SIZE_W +: SIZE_W];
    assign w_h[g]   = req_h[g*SIZE_W +: SIZE_W];
  end

  logic [0:0]          r_state;
  logic [2:0]          r_last;
  logic [2:0]          r_grant;
  logic [X_W-1:0]      r_x0;
  logic [Y_W-1:0]      r_y0;
  logic [COLOUR_W-1:0] r_col;
  logic [SIZE_W-1:0]   r_w, r_h, r_dx, r_dy;
  logic [X_W-1:0]      r_X;
  logic [Y_W-1:0]      r_Y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_we;

  // Rotating priority: lowest valid index above the pointer, else lowest at/below it.
  logic       w_hi_any, w_lo_any, w_any;
  logic [2:0] w_hi, w_lo, w_win;
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi     = '0;
    w_lo     = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (3'(i) > r_last) begin
          w_hi_any = 1'b1;
          w_hi     = 3'(i);
        end else begin
          w_lo_any = 1'b1;
          w_lo     = 3'(i);
        end
      end
    end
  end
  assign w_any = w_hi_any | w_lo_any;
  assign w_win = w_hi_any ? w_hi : w_lo;

  logic [X_W-1:0]      w_sel_x;
  logic [Y_W-1:0]      w_sel_y;
  logic [COLOUR_W-1:0] w_sel_col;
  logic [SIZE_W-1:0]   w_sel_w, w_sel_h;
  always_comb begin
    w_sel_x   = '0;
    w_sel_y   = '0;
    w_sel_col = '0;
    w_sel_w   = '0;
    w_sel_h   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (3'(i) == w_win) begin
        w_sel_x      = w_x[i];
        w_sel_y      = w_y[i];
        w_sel_col    = w_col[i];
        w_sel_w      = w_w[i];
        w_sel_h      = w_h[i];
        req_ready[i] = reset_n && (r_state == ST_IDLE) && w_any;
      end
    end
  end

  // One extra bit on the sums so off-screen pixels are clipped, not wrapped.
  logic [X_W:0] w_sx;
  logic [Y_W:0] w_sy;
  logic         w_on;
  assign w_sx = {1'b0, r_x0} + {{(X_W+1-SIZE_W){1'b0}}, r_dx};
  assign w_sy = {1'b0, r_y0} + {{(Y_W+1-SIZE_W){1'b0}}, r_dy};
  assign w_on = (w_sx < (X_W+1)'(H_RES)) && (w_sy < (Y_W+1)'(V_RES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_last   <= 3'(NUM_CH-1);
      r_grant  <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_col    <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_X      <= '0;
      r_Y      <= '0;
      r_colour <= '0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_we <= 1'b0;
          if (w_any) begin
            r_x0    <= w_sel_x;
            r_y0    <= w_sel_y;
            r_col   <= w_sel_col;
            r_w     <= w_sel_w;
            r_h     <= w_sel_h;
            r_last  <= w_win;
            r_grant <= w_win;
            r_dx    <= '0;
            r_dy    <= '0;
            r_state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          r_we     <= w_on;
          r_X      <= w_sx[X_W-1:0];
          r_Y      <= w_sy[Y_W-1:0];
          r_colour <= r_col;
          if (r_dx == r_w) begin
            r_dx <= '0;
            if (r_dy == r_h) r_state <= ST_IDLE;
            else             r_dy    <= r_dy + 1'b1;
          end else begin
            r_dx <= r_dx + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign X        = r_X;
  assign Y        = r_Y;
  assign colour   = r_colour;
  assign writeEn  = r_we;
  assign busy     = (r_state == ST_DRAW);
  assign grant_id = r_grant;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter with three clients: scan order, clipping,
// round-robin fairness, async reset abort and accept-edge data capture.
module tb_plot_arbiter;
  localparam int NCH = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH-1:0]    req_ready;
  logic [NCH*8-1:0]  req_x = '0;
  logic [NCH*7-1:0]  req_y = '0;
  logic [NCH*6-1:0]  req_colour = '0;
  logic [NCH*3-1:0]  req_w = '0;
  logic [NCH*3-1:0]  req_h = '0;
  logic [7:0]        X;
  logic [6:0]        Y;
  logic [5:0]        colour;
  logic              writeEn, busy;
  logic [2:0]        grant_id;

  plot_arbiter #(.NUM_CH(NCH)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_w(req_w), .req_h(req_h),
    .X(X), .Y(Y), .colour(colour), .writeEn(writeEn), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int x; int y; int col; } pix_t;
  typedef struct { int c; int ch; } acc_t;

  pix_t plog[$];
  acc_t alog[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   rdy0_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (writeEn) plog.push_back('{cyc, int'(X), int'(Y), int'(colour)});
    if (busy) busy_cnt++;
    if (req_ready[0]) rdy0_cnt++;
    for (int i = 0; i < NCH; i++)
      if (req_valid[i] && req_ready[i]) alog.push_back('{cyc, i});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int ch, input int x, input int y, input int col,
                         input int w, input int h);
    req_x[ch*8 +: 8]      = 8'(x);
    req_y[ch*7 +: 7]      = 7'(y);
    req_colour[ch*6 +: 6] = 6'(col);
    req_w[ch*3 +: 3]      = 3'(w);
    req_h[ch*3 +: 3]      = 3'(h);
  endtask

  task automatic send(input int ch, input int x, input int y, input int col,
                      input int w, input int h, output int acc);
    int got;
    got = 0;
    acc = -1;
    @(posedge clk); #1;
    set_req(ch, x, y, col, w, h);
    req_valid[ch] = 1'b1;
    for (int t = 0; t < 200 && got == 0; t++) begin
      @(negedge clk);
      if (req_ready[ch]) begin got = 1; acc = cyc; end
    end
    chk("accept_timeout", got, 1);
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy && req_valid == '0) break;
    end
    chk("idle_timeout", t < 300, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    plog.delete();
    alog.delete();
    busy_cnt = 0;
    rdy0_cnt = 0;
  endtask

  int acc, k, got;
  logic [NCH-1:0] w_rdy;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_X", X, 0);
    chk("rst_Y", Y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_we", writeEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Single pixel from ch0
    clear_logs();
    send(0, 10, 20, 6'h30, 0, 0, acc);
    wait_idle();
    chk("sp_rdy_cycles", rdy0_cnt, 1);
    chk("sp_npix", plog.size(), 1);
    if (plog.size() == 1) begin
      chk("sp_x", plog[0].x, 10);
      chk("sp_y", plog[0].y, 20);
      chk("sp_col", plog[0].col, 6'h30);
      chk("sp_lat", plog[0].c - acc, 2);
    end
    chk("sp_busy", busy, 0);
    chk("sp_grant", grant_id, 0);

    // 4x2 rectangle from ch1, row-major on consecutive cycles
    clear_logs();
    send(1, 5, 7, 6'h0c, 3, 1, acc);
    wait_idle();
    chk("rect_npix", plog.size(), 8);
    if (plog.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("rect_x%0d", i), plog[i].x, 5 + i % 4);
        chk($sformatf("rect_y%0d", i), plog[i].y, 7 + i / 4);
        chk($sformatf("rect_c%0d", i), plog[i].c, acc + 2 + i);
      end
    chk("rect_grant", grant_id, 1);

    // Clipping at bottom-right corner
    clear_logs();
    send(2, 158, 119, 6'h3f, 3, 1, acc);
    wait_idle();
    chk("clip_npix", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("clip_x0", plog[0].x, 158);
      chk("clip_y0", plog[0].y, 119);
      chk("clip_x1", plog[1].x, 159);
      chk("clip_y1", plog[1].y, 119);
      chk("clip_c1", plog[1].c, acc + 3);
    end
    chk("clip_draw_cycles", busy_cnt, 8);

    // Round-robin after a fresh reset: all three valid, 1x1 each
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    clear_logs();
    for (int i = 0; i < NCH; i++) set_req(i, 100 + i, 10 + i, i, 0, 0);
    req_valid = '1;
    got = 0;
    for (int t = 0; t < 100 && got == 0; t++) begin
      @(negedge clk);
      if (alog.size() >= 6) got = 1;
    end
    chk("rr_timeout", got, 1);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    chk("rr_nacc", alog.size(), 6);
    if (alog.size() >= 6)
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("rr_ch%0d", i), alog[i].ch, i % 3);
        if (i > 0) chk($sformatf("rr_gap%0d", i), alog[i].c - alog[i-1].c, 2);
      end
    chk("rr_npix", plog.size(), 6);
    if (plog.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("rr_px%0d", i), plog[i].x, 100 + i % 3);

    // Data captured on the accept edge only: ch0 waits behind a 2x2 from ch1
    clear_logs();
    @(posedge clk); #1;
    set_req(1, 60, 60, 1, 1, 1);
    req_valid[1] = 1'b1;
    got = 0;
    for (int t = 0; t < 50 && got == 0; t++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1;
    end
    chk("hold_acc1", got, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    k = 40;
    set_req(0, k, 50, k, 0, 0);
    req_valid[0] = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
      else begin
        @(posedge clk); #1;
        k++;
        set_req(0, k, 50, k, 0, 0);
      end
    end
    chk("hold_acc0", got, 1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_idle();
    chk("hold_npix", plog.size(), 5);
    if (plog.size() == 5) begin
      chk("hold_x", plog[4].x, 44);
      chk("hold_col", plog[4].col, 44);
    end

    // Async reset during pixel 3 of a 4x4 from ch1
    clear_logs();
    @(posedge clk); #1;
    set_req(1, 0, 0, 6'h15, 3, 3);
    req_valid[1] = 1'b1;
    k = 0;
    for (int t = 0; t < 50 && k < 3; t++) begin
      @(posedge clk); #2;
      if (req_ready[1]) req_valid[1] = 1'b0;
      if (writeEn) k++;
    end
    chk("mid_pix3", k, 3);
    reset_n = 1'b0;
    #1;
    chk("mid_we", writeEn, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 0);
    req_valid = '0;
    plog.delete();
    alog.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    set_req(0, 1, 1, 6'h01, 0, 0);
    set_req(1, 2, 2, 6'h02, 0, 0);
    req_valid = 3'b011;
    for (int t = 0; t < 100 && req_valid != '0; t++) begin
      @(negedge clk);
      w_rdy = req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~w_rdy;
    end
    wait_idle();
    chk("post_nacc", alog.size(), 2);
    if (alog.size() == 2) begin
      chk("post_first", alog[0].ch, 0);
      chk("post_second", alog[1].ch, 1);
    end
    chk("post_npix", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("post_px0", plog[0].x, 1);
      chk("post_px1", plog[1].x, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Parametrised multi-client pixel-plot front end for the 160x120 VGA adapter.
- Replaces the single hard-wired X/Y/colour/writeEn path from the game controller.
- NUM_CH drawing clients each submit rectangle-fill requests over valid/ready handshakes.
- The block grants requests round-robin and serialises each rectangle into one pixel per clock, clipping any pixel outside the screen.

Parameters:
- NUM_CH, 2, number of client channels (1..8).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 6, colour width (2 bits per channel).
- SIZE_W, 3, width of rectangle size fields; a field value of n means n+1 pixels.
- H_RES, 160, visible columns; x >= H_RES is clipped.
- V_RES, 120, visible rows; y >= V_RES is clipped.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept; at most one bit high.
- req_x  in  NUM_CH*X_W  packed origin x; channel i occupies bits [i*X_W +: X_W].
- req_y  in  NUM_CH*Y_W  packed origin y.
- req_colour  in  NUM_CH*COLOUR_W  packed fill colour.
- req_w  in  NUM_CH*SIZE_W  packed width-1.
- req_h  in  NUM_CH*SIZE_W  packed height-1.
- X  out  X_W  pixel x to vga_adapter.
- Y  out  Y_W  pixel y to vga_adapter.
- colour  out  COLOUR_W  pixel colour.
- writeEn  out  1  plot strobe.
- busy  out  1  high in DRAW.
- grant_id  out  3  index of the channel currently or last granted.

Behaviour:
- **Reset.** Async, active-low. X, Y, colour, writeEn, busy, grant_id, req_ready and all counters go to 0. State goes to IDLE. The round-robin pointer last_grant is set to NUM_CH-1, so channel 0 wins first. Reset asserted mid-rectangle aborts it immediately; the remaining pixels are never drawn.
- **States:** IDLE, DRAW.
- **IDLE.**
  - The combinational winner is the first i with req_valid[i]=1, searching from last_grant+1 modulo NUM_CH upward.
  - req_ready[winner]=1 in the same cycle. req_ready depends only on state and req_valid, never on itself.
  - Handshake completes on the edge where valid&ready=1. The block then latches the winner's x0, y0, colour, w, h, sets last_grant=grant_id=winner, clears dx=dy=0, and goes to DRAW.
  - With no valid input, writeEn=0 and the block stays in IDLE.
- **DRAW.**
  - Each cycle emits pixel (x0+dx, y0+dy).
  - Sums are computed at X_W+1 / Y_W+1 bits, so there is no wrap-around.
  - writeEn, X, Y and colour are registered: the pixel for counter value (dx,dy) appears one cycle later. The first pixel's writeEn is high 2 cycles after the accept edge.
  - writeEn=1 only if the sum is x < H_RES and y < V_RES. A clipped pixel still consumes its cycle, with writeEn=0; X and Y hold the truncated sum (don't-care).
  - Scan order is row-major: dx increments. When dx==w, dx returns to 0 and dy increments. When dx==w and dy==h, the next state is IDLE.
  - Total DRAW cycles = (w+1)*(h+1). The maximum is 64 with SIZE_W=3.
  - req_ready is 0 for all channels throughout DRAW; requesters must hold valid and data stable.
- **Timing.** One IDLE cycle always separates consecutive rectangles. Sustained throughput is (w+1)(h+1) pixels per (w+1)(h+1)+1 cycles.
- **busy** = (state==DRAW), driven from the state register.
- **writeEn** goes low on the cycle after the last pixel's writeEn.
- **Simultaneous valids.** Only one grant is issued per IDLE cycle; the other channels wait, and no request is dropped.
- **Valid deasserted while waiting (protocol violation).** The request is simply not granted; no state is kept.
- **NUM_CH=1.** Degenerates to a single-client rasteriser; the pointer is a constant.

Test Plan:
- **Reset and single pixel.** Reset, then ch0 requests x=10 y=20 colour=6'h30 w=0 h=0. Required: req_ready[0] high 1 cycle; exactly one writeEn pulse, with X=10, Y=20, colour=6'h30, 2 cycles after accept; then busy=0.
- **Rectangle scan.** ch1 requests x=5 y=7 w=3 h=1. Required: 8 consecutive writeEn cycles in the order (5,7),(6,7),(7,7),(8,7),(5,8),(6,8),(7,8),(8,8); grant_id=1.
- **Round-robin fairness.** NUM_CH=3, all valids held high with 1x1 requests. Required grant order 0,1,2,0,1,2, each accept separated by exactly one bubble cycle.
- **Clipping.** Request x=158 y=119 w=3 h=1. Required: writeEn only for (158,119) and (159,119); the other 6 pixel cycles have writeEn=0; DRAW lasts 8 cycles.
- **Reset mid-draw.** Assert reset_n=0 during pixel 3 of a 4x4 rectangle. Required: writeEn=0 and busy=0 immediately (asynchronously). After release, ch0 is granted first, and no stale pixels are emitted.
- **Back-to-back hold.** ch0 holds valid with changing data while it is not ready. Required: the data latched is the value present on the accept edge only.
